ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter TIMEOUT_CYC, default 5000: i_clk cycles without a PS/2 clock falling edge before an in-progress frame is aborted.
REQ-002 i_clk  input  1  system clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous assert, active-low; deasserts synchronously with i_clk.
REQ-004 i_ps2_clk  input  1  PS/2 clock line from the keyboard, asynchronous to i_clk.
REQ-005 i_ps2_data  input  1  PS/2 data line from the keyboard, asynchronous to i_clk.
REQ-006 o_byte  output  8  last received scan-code byte; drives KBUF i_byte.
REQ-007 o_op  output  `SFR_OP_LEN  SFR operation; drives KBUF i_op.
REQ-008 o_err  output  1  one-cycle pulse on frame error or timeout.

Function
REQ-009 i_ps2_clk and i_ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected from the synchronized clock with one further register stage.
REQ-010 Data SHALL be sampled only in the i_clk cycle in which a synchronized PS/2 clock falling edge is detected.
REQ-011 FSM states: IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: on a falling edge with data=0 (start bit) go to DATA and clear the bit counter; with data=1, stay in IDLE, no error.
REQ-013 DATA: shift in 8 bits, LSB first, using a 3-bit counter; after the 8th bit go to PARITY.
REQ-014 PARITY: capture the parity bit; the frame requires odd parity over 8 data bits plus parity; go to STOP.
REQ-015 STOP: on a falling edge, if stop bit=1 and parity is valid, the frame is good; otherwise it is bad; in both cases return to IDLE.
REQ-016 Good frame: in the cycle after the stop-bit sample, o_byte SHALL take the received byte and o_op SHALL equal `OP_KBUF_WR_BYTE for exactly one cycle.
REQ-017 o_op SHALL be zero in every other cycle.
REQ-018 o_byte SHALL hold its value between good frames.
REQ-019 Bad frame: o_err SHALL pulse for one cycle, o_op SHALL stay zero, and o_byte SHALL be unchanged.
REQ-020 Timeout: in any state other than IDLE, a free-running counter SHALL clear on each falling edge.
REQ-021 Timeout: when the counter reaches TIMEOUT_CYC-1, the FSM SHALL go to IDLE and o_err SHALL pulse for one cycle.
REQ-022 The timeout counter SHALL be held at zero in IDLE and SHALL saturate rather than wrap.
REQ-023 Latency from the PS/2 clock falling edge of the stop bit to o_op asserted SHALL be 4 i_clk cycles: 2 sync, 1 edge detect, 1 output register.
REQ-024 Back-to-back frames with no idle gap beyond the stop bit SHALL each be received correctly.

Reset
REQ-025 While i_rst=0: FSM in IDLE, bit counter 0, timeout counter 0, shift register 0x00, o_byte=0x00, o_op=0, o_err=0.
REQ-026 Synchronizer flops SHALL reset to 1, the idle line level.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no o_op or o_err pulse SHALL follow reset release.

Configuration
REQ-028 Macro PS2_BREAK_FILTER_EN.
REQ-029 When PS2_BREAK_FILTER_EN is defined, a good frame carrying 0xF0 SHALL set a break flag and SHALL NOT assert o_op.
REQ-030 When PS2_BREAK_FILTER_EN is defined, the next good frame after the break flag is set SHALL clear the flag, SHALL NOT assert o_op, and SHALL leave o_byte unchanged; only make codes reach KBUF.
REQ-031 When PS2_BREAK_FILTER_EN is defined, the break flag SHALL clear on reset and SHALL NOT be affected by bad frames or timeouts.
REQ-032 When PS2_BREAK_FILTER_EN is not defined, every good frame, including 0xF0, SHALL be written per REQ-016 and no break-flag logic SHALL exist.

Verification
REQ-033 Good frame: frame 0x1C, parity 0, stop 1 -> o_byte=0x1C, one-cycle o_op=`OP_KBUF_WR_BYTE 4 cycles after the stop edge, o_err=0.
REQ-034 Parity error: frame 0x5A with parity 0 -> o_err pulses once, no o_op pulse, o_byte keeps its prior value.
REQ-035 Timeout: send start bit plus 3 data bits, then idle TIMEOUT_CYC cycles -> o_err pulse, FSM in IDLE; a following 0x1C frame is received correctly.
REQ-036 Break sequence: send 0x1C, then 0xF0, then 0x1C -> filter enabled: exactly one o_op pulse and o_byte=0x1C; filter disabled: three o_op pulses and final o_byte=0x1C.
REQ-037 Reset mid-frame: assert i_rst=0 after the 4th data bit, release, then send 0x29 (parity 0) -> no pulse at reset release, then o_byte=0x29 with one o_op pulse.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, deframes 11-bit frames and writes good scan codes to KBUF.
// Optional macro PS2_BREAK_FILTER_EN drops break codes (0xF0 and the byte that follows it).

`ifndef SFR_OP_LEN
`define SFR_OP_LEN 4
`endif
`ifndef OP_KBUF_WR_BYTE
`define OP_KBUF_WR_BYTE 4'd1
`endif

module ps2_kbd_rx #(
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_ps2_clk,
   input  logic                   i_ps2_data,
   output logic [7:0]             o_byte,
   output logic [`SFR_OP_LEN-1:0] o_op,
   output logic                   o_err,
   output logic [1:0]             o_state
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [`SFR_OP_LEN-1:0] OP_WR = `OP_KBUF_WR_BYTE;

   // o_state encoding: IDLE=0, DATA=1, PARITY=2, STOP=3
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   logic clk_s1_q, clk_s2_q, clk_s3_q;
   logic dat_s1_q, dat_s2_q, dat_s3_q;
   logic fall_q, fall_d;

   state_t                 state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [TW-1:0]          to_q, to_d;
   logic [7:0]             shift_q, shift_d;
   logic                   par_q, par_d;
   logic [7:0]             byte_q, byte_d;
   logic [`SFR_OP_LEN-1:0] op_q, op_d;
   logic                   err_q, err_d;
`ifdef PS2_BREAK_FILTER_EN
   logic                   brk_q, brk_d;
`endif

   // fall_q is the registered edge strobe; dat_s3_q keeps data aligned with it.
   assign fall_d = clk_s3_q & ~clk_s2_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
         dat_s3_q <= 1'b1;
         fall_q   <= 1'b0;
      end else begin
         clk_s1_q <= i_ps2_clk;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= i_ps2_data;
         dat_s2_q <= dat_s1_q;
         dat_s3_q <= dat_s2_q;
         fall_q   <= fall_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         to_q    <= '0;
         shift_q <= 8'h00;
         par_q   <= 1'b0;
         byte_q  <= 8'h00;
         op_q    <= '0;
         err_q   <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
         brk_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         byte_q  <= byte_d;
         op_q    <= op_d;
         err_q   <= err_d;
`ifdef PS2_BREAK_FILTER_EN
         brk_q   <= brk_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      shift_d = shift_q;
      par_d   = par_q;
      byte_d  = byte_q;
      op_d    = '0;
      err_d   = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk_d   = brk_q;
`endif

      case (state_q)
         IDLE: begin
            if (fall_q && !dat_s3_q) begin
               state_d = DATA;
               cnt_d   = 3'd0;
            end
         end
         DATA: begin
            if (fall_q) begin
               shift_d = {dat_s3_q, shift_q[7:1]};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fall_q) begin
               par_d   = dat_s3_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall_q) begin
               state_d = IDLE;
               if (dat_s3_q && (^{shift_q, par_q})) begin
`ifdef PS2_BREAK_FILTER_EN
                  if (brk_q) begin
                     brk_d = 1'b0;
                  end else if (shift_q == 8'hF0) begin
                     brk_d = 1'b1;
                  end else begin
                     byte_d = shift_q;
                     op_d   = OP_WR;
                  end
`else
                  byte_d = shift_q;
                  op_d   = OP_WR;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Watchdog runs only mid-frame; a PS/2 edge restarts it.
      if (state_q == IDLE) begin
         to_d = '0;
      end else if (fall_q) begin
         to_d = '0;
      end else if (to_q == TO_LAST) begin
         state_d = IDLE;
         err_d   = 1'b1;
         to_d    = '0;
      end else if (to_q != '1) begin
         to_d = to_q + 1'b1;
      end
   end

   assign o_byte  = byte_q;
   assign o_op    = op_q;
   assign o_err   = err_q;
   assign o_state = state_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus random back-to-back frames
// checked against a frame-level reference model (honours PS2_BREAK_FILTER_EN).

`ifndef SFR_OP_LEN
`define SFR_OP_LEN 4
`endif
`ifndef OP_KBUF_WR_BYTE
`define OP_KBUF_WR_BYTE 4'd1
`endif

module tb_ps2_kbd_rx;

   localparam int TO   = 200;
   localparam int HALF = 10;
   localparam logic [`SFR_OP_LEN-1:0] OP_WR = `OP_KBUF_WR_BYTE;
   localparam logic [1:0] ST_IDLE = 2'd0;

   logic                   clk      = 1'b0;
   logic                   rst_n    = 1'b0;
   logic                   ps2_clk  = 1'b1;
   logic                   ps2_data = 1'b1;
   logic [7:0]             o_byte;
   logic [`SFR_OP_LEN-1:0] o_op;
   logic                   o_err;
   logic [1:0]             o_state;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         exp_err  = 0;
   int         got_err  = 0;
   logic [7:0] exp_byte = 8'h00;
   logic       brk      = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   ps2_kbd_rx #(.TIMEOUT_CYC(TO)) dut (
      .i_clk      (clk),
      .i_rst      (rst_n),
      .i_ps2_clk  (ps2_clk),
      .i_ps2_data (ps2_data),
      .o_byte     (o_byte),
      .o_op       (o_op),
      .o_err      (o_err),
      .o_state    (o_state)
   );

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (o_op !== '0) begin
         got_q.push_back(o_byte);
         total++;
         if (o_op !== OP_WR) begin
            bad++;
            $display("FAIL op_code got=%h exp=%h", o_op, OP_WR);
         end
      end
      if (o_err === 1'b1) got_err++;
   end

   // ---------------- reference model ----------------
   task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
      if (stop && (^{b, par})) begin
`ifdef PS2_BREAK_FILTER_EN
         if (brk) brk = 1'b0;
         else if (b == 8'hF0) brk = 1'b1;
         else begin
            exp_q.push_back(b);
            exp_byte = b;
         end
`else
         exp_q.push_back(b);
         exp_byte = b;
`endif
      end else begin
         exp_err++;
      end
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      exp_err = 0;
      got_err = 0;
   endtask

   // ---------------- drivers ----------------
   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      ps2_bit(stop);
      ps2_data = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (o_byte !== 8'h00 || o_op !== '0 || o_err !== 1'b0 || o_state !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_vals got byte=%h op=%h err=%b st=%0d exp 00/0/0/0", o_byte, o_op, o_err, o_state);
      end
      rst_n = 1'b1;
      clear_sb();
      repeat (10) @(negedge clk);
      total++;
      if (got_q.size() != 0 || got_err != 0) begin
         bad++;
         $display("FAIL reset_release got ops=%0d errs=%0d exp 0/0", got_q.size(), got_err);
      end
   endtask

   task automatic test_good_frame();
      logic [7:0] b;
      clear_sb();
      b = 8'h1C;
      model_frame(b, 1'b0, 1'b1);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(1'b0);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         total++;
         if (o_op !== ((k == 4) ? OP_WR : '0) || o_err !== 1'b0) begin
            bad++;
            $display("FAIL latency_c%0d got op=%h err=%b exp op=%h err=0", k, o_op, o_err,
                     (k == 4) ? OP_WR : '0);
         end
      end
      repeat (HALF - 5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (got_q.size() != 1 || got_err != 0 || o_byte !== 8'h1C) begin
         bad++;
         $display("FAIL good_frame got ops=%0d errs=%0d byte=%h exp 1/0/1c", got_q.size(), got_err, o_byte);
      end
   endtask

   task automatic test_parity_error();
      clear_sb();
      model_frame(8'h5A, 1'b0, 1'b1);
      send_frame(8'h5A, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      total++;
      if (got_q.size() != exp_q.size() || got_err != exp_err) begin
         bad++;
         $display("FAIL parity_err got ops=%0d errs=%0d exp %0d/%0d", got_q.size(), got_err, exp_q.size(), exp_err);
      end
      total++;
      if (o_byte !== exp_byte) begin
         bad++;
         $display("FAIL parity_byte got=%h exp=%h", o_byte, exp_byte);
      end
   endtask

   task automatic test_timeout();
      clear_sb();
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)));
      exp_err = 1;
      repeat (TO + 50) @(negedge clk);
      total++;
      if (got_err != exp_err || got_q.size() != 0 || o_state !== ST_IDLE) begin
         bad++;
         $display("FAIL timeout got errs=%0d ops=%0d st=%0d exp 1/0/0", got_err, got_q.size(), o_state);
      end
      clear_sb();
      model_frame(8'h1C, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      total++;
      if (got_q.size() != 1 || got_err != 0 || o_byte !== exp_byte) begin
         bad++;
         $display("FAIL timeout_recover got ops=%0d errs=%0d byte=%h exp 1/0/%h", got_q.size(), got_err, o_byte, exp_byte);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      b = 8'h29;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(b[i]);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      exp_byte = 8'h00;
      brk      = 1'b0;
      clear_sb();
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      total++;
      if (got_q.size() != 0 || got_err != 0 || o_byte !== 8'h00) begin
         bad++;
         $display("FAIL rst_mid got ops=%0d errs=%0d byte=%h exp 0/0/00", got_q.size(), got_err, o_byte);
      end
      model_frame(b, 1'b0, 1'b1);
      send_frame(b, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      total++;
      if (got_q.size() != 1 || got_err != 0 || o_byte !== 8'h29) begin
         bad++;
         $display("FAIL rst_mid_rx got ops=%0d errs=%0d byte=%h exp 1/0/29", got_q.size(), got_err, o_byte);
      end
   endtask

   task automatic test_break();
      logic [7:0] seq [3];
      seq[0] = 8'h1C;
      seq[1] = 8'hF0;
      seq[2] = 8'h1C;
      clear_sb();
      for (int i = 0; i < 3; i++) begin
         model_frame(seq[i], ~^seq[i], 1'b1);
         send_frame(seq[i], ~^seq[i], 1'b1);
      end
      repeat (20) @(negedge clk);
      total++;
      if (got_q.size() != exp_q.size() || got_err != 0) begin
         bad++;
         $display("FAIL break_count got ops=%0d errs=%0d exp %0d/0", got_q.size(), got_err, exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL break_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      total++;
      if (o_byte !== 8'h1C) begin
         bad++;
         $display("FAIL break_final got=%h exp=1c", o_byte);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      logic       par, stop;
      clear_sb();
      for (int n = 0; n < 16; n++) begin
         b    = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) b = 8'hF0;
         par  = ~^b;
         if ($urandom_range(0, 3) == 0) par = ~par;
         stop = ($urandom_range(0, 7) != 0);
         model_frame(b, par, stop);
         send_frame(b, par, stop);
      end
      repeat (20) @(negedge clk);
      total++;
      if (got_q.size() != exp_q.size() || got_err != exp_err) begin
         bad++;
         $display("FAIL b2b_count got ops=%0d errs=%0d exp %0d/%0d", got_q.size(), got_err, exp_q.size(), exp_err);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      total++;
      if (o_byte !== exp_byte) begin
         bad++;
         $display("FAIL b2b_final got=%h exp=%h", o_byte, exp_byte);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_timeout();
      test_reset_mid_frame();
      test_break();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
